// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; produces {remainder, quotient}
// after DW iterations and holds it while start stays high.
module div_iter #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div,
  input  logic [DW-1:0]   opdata1,
  input  logic [DW-1:0]   opdata2,
  input  logic            start,
  input  logic            annul,
  output logic [2*DW-1:0] result,
  output logic            ready,
  output logic            stall_req
);

  typedef enum logic [1:0] {StIdle, StDivZero, StOn, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [DW-1:0]     dvs_q, dvs_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic [2*DW-1:0]   result_q, result_d;
  logic              ready_q, ready_d;

  logic              in_sign1, in_sign2;
  logic [DW-1:0]     in_abs1, in_abs2;
  logic [DW:0]       shifted, diff;
  logic              qbit;
  logic [DW-1:0]     rem_next, quo_next, rem_fix, quo_fix, raw_op1;

  assign in_sign1 = signed_div & opdata1[DW-1];
  assign in_sign2 = signed_div & opdata2[DW-1];
  assign in_abs1  = in_sign1 ? -opdata1 : opdata1;
  assign in_abs2  = in_sign2 ? -opdata2 : opdata2;

  assign shifted  = {rem_q, dvd_q[DW-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign qbit     = ~diff[DW];
  assign rem_next = qbit ? diff[DW-1:0] : shifted[DW-1:0];
  assign quo_next = {dvd_q[DW-2:0], qbit};
  assign quo_fix  = (sign1_q ^ sign2_q) ? -quo_next : quo_next;
  assign rem_fix  = sign1_q ? -rem_next : rem_next;
  // Divide-by-zero returns the dividend as given, so undo the magnitude taken on accept
  assign raw_op1  = sign1_q ? -dvd_q : dvd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      StIdle: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start && !annul) begin
          sign1_d = in_sign1;
          sign2_d = in_sign2;
          dvd_d   = in_abs1;
          dvs_d   = in_abs2;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (opdata2 == '0) ? StDivZero : StOn;
        end
      end
      StDivZero: begin
        if (annul || !start) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          result_d = {raw_op1, {DW{1'b1}}};
          ready_d  = 1'b1;
        end
      end
      StOn: begin
        if (annul || !start) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_d  = StDone;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      StDone: begin
        if (annul || !start) begin
          state_d  = StIdle;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_req = start & ~ready_q;

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage, running alongside the ALU.
- Produces the 64-bit {HI, LO} = {remainder, quotient} pair that the HI/LO register writes. The ALU later reads that pair back as its hilo input for MFHI/MFLO.
- Holds the pipeline via stall_req until the result is valid.
- Supports an annul input so an exception flush can cancel an in-flight division.

Parameters:
- DW, 32, operand width (quotient and remainder are each DW bits; result is 2*DW bits)
- CW, 6, iteration counter width (must hold DW)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled on accept
- opdata1  input  DW  dividend (rs); sampled on accept
- opdata2  input  DW  divisor (rt); sampled on accept
- start  input  1  request; held high by EX control for as long as the divide instruction occupies EX
- annul  input  1  cancel current operation (exception/flush)
- result  output  2*DW  {remainder, quotient}; valid only while ready=1, 0 otherwise
- ready  output  1  result valid
- stall_req  output  1  combinational: start & ~ready

Behaviour:
- Reset (async): state=IDLE, result=0, ready=0, counter=0, internal dividend/divisor/partial-remainder registers=0.
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - Accept when start=1 and annul=0. Latch |opdata1| and |opdata2| into internal registers, plus sign bits for signed_div=1. Unsigned operands are taken as is.
  - Go to DIVZERO if opdata2==0, else to ON with counter=0.
  - ready=0 and result=0 in IDLE.
- DIVZERO: one cycle, then DONE with quotient=all ones and remainder=raw opdata1. This is fixed team behaviour for an architecturally undefined case.
- ON:
  - Each cycle shift the partial remainder left by one and bring in the next dividend bit (MSB first).
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the old value and shift in 0.
  - counter increments each cycle. On the cycle with counter==DW-1, go to DONE.
- Transition into DONE:
  - Apply sign fix-up when signed_div=1: quotient negated if sign(op1)^sign(op2); remainder negated if sign(op1).
  - Register result and set ready=1 on that same edge.
- DONE:
  - Hold result and ready while start=1.
  - When start=0, go to IDLE next edge, clearing ready and result.
  - A new start is not accepted in DONE; the next op needs a return to IDLE.
- Latency: counting the accepting edge as edge 1, ready is high after edge DW+1 (33 for DW=32) for a nonzero divisor, and after edge 2 for a zero divisor.
- annul:
  - In DIVZERO, ON or DONE, forces IDLE on the next edge with ready=0 and result=0. The partial result is discarded.
  - Wins over the counter reaching its end on the same edge.
  - annul in IDLE blocks acceptance.
- start dropping in ON or DIVZERO (e.g. flush without annul): treated as annul, and the block returns to IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap), with no trap or flag.
- Operands change after accept: ignored; only latched copies are used.
- Reset asserted mid-operation: immediate return to reset values, with no glitching of ready to 1.
- stall_req is purely combinational from start and ready and carries no other logic.

Test Plan:
- DIVU, op1=100, op2=7, start held → ready after edge 33; result={32'd2, 32'd14}. Drop start → next edge ready=0, result=0.
- DIV, op1=0xFFFFFFF9 (-7), op2=2 → result={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3).
  - Also op1=7, op2=0xFFFFFFFE → {32'd1, 32'hFFFFFFFD}.
- Divide by zero, DIVU op1=5, op2=0 → ready after edge 2; result={32'd5, 32'hFFFFFFFF}.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}.
  - Also DIVU 0xFFFFFFFF / 1 → {32'h0, 32'hFFFFFFFF}.
  - Also DIVU 3 / 10 → {32'd3, 32'd0}.
- Pulse annul at iteration 15 → ready never rises and the block is IDLE next edge.
  - A following DIVU 9/3 completes normally with {0, 3} after 33 edges.
  - Repeat with annul coinciding with the final iteration edge: ready must stay 0.
- Assert rst asynchronously mid-ON: outputs 0 immediately. Change opdata1 and opdata2 during ON on a separate run: the result matches the originally latched operands. stall_req=1 exactly while start=1 and ready=0.
